nios_system_addr_seq: RTL and testbench

NIOS_SYSTEM_ADDR_SEQ -- requirements
Module: nios_system_addr_seq

---
 rtl/nios_system_addr_seq_pkg.sv | 25 ++
 rtl/nios_system_addr_seq.sv | 151 +++++++++++++++
 tb/tb_nios_system_addr_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nios_system_addr_seq_pkg.sv
// Register offsets, CTRL/STATUS bit positions and sequencer state encoding
// shared by the address sequencer and anything that drives its slave port.
package nios_system_addr_seq_pkg;

    localparam logic [1:0] REG_BASE  = 2'd0;
    localparam logic [1:0] REG_COUNT = 2'd1;
    localparam logic [1:0] REG_DATA  = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_IRQ_EN  = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/nios_system_addr_seq.sv
// Avalon-MM programmed fill sequencer: writes DATA to COUNT words from BASE; irq optional via ADDR_SEQ_IRQ_EN.
// Latency: first out_wr the cycle after start, then one word per cycle; readdata is zero-latency.
// Backpressure: out_addr/out_data hold while out_wr && !out_ready; no internal buffering.
module nios_system_addr_seq
    import nios_system_addr_seq_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter int STRIDE  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        out_wr,
    input  logic        out_ready,
    output logic        irq
);

    state_t               state, state_n;
    logic [31:0]          base, base_n, data, data_n, addr_n;
    logic [COUNT_W-1:0]   count, count_n, remaining, rem_n;
    logic                 done, done_n, aborted, aborted_n;
    logic                 irq_en;
    logic                 slv_wr, ctrl_wr, start, abort, busy;

    assign slv_wr  = chipselect && !write_n;
    assign ctrl_wr = slv_wr && (address == REG_CTRL);
    // Abort wins over start when both bits arrive in one write.
    assign abort   = ctrl_wr && writedata[CTRL_ABORT];
    assign start   = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_ABORT];
    assign busy    = (state != ST_IDLE);
    assign out_wr  = (state == ST_ISSUE);
    assign out_data = data;

    always_comb begin
        state_n   = state;
        base_n    = base;
        count_n   = count;
        data_n    = data;
        rem_n     = remaining;
        addr_n    = out_addr;
        done_n    = done;
        aborted_n = aborted;
        if (slv_wr && !busy) begin
            case (address)
                REG_BASE:  base_n  = writedata;
                REG_COUNT: count_n = writedata[COUNT_W-1:0];
                REG_DATA:  data_n  = writedata;
                default:   ;
            endcase
        end
        if (ctrl_wr && writedata[CTRL_CLR])
            done_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    done_n    = 1'b0;
                    aborted_n = 1'b0;
                    if (count != '0) begin
                        addr_n  = base;
                        rem_n   = count;
                        state_n = ST_ISSUE;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (out_ready) begin
                    addr_n = out_addr + 32'(STRIDE);
                    rem_n  = remaining - COUNT_W'(1);
                    if (remaining == COUNT_W'(1))
                        state_n = ST_DONE;
                end
                // A word accepted alongside the abort still counts above.
                if (abort) begin
                    state_n   = ST_IDLE;
                    aborted_n = 1'b1;
                end
            end
            ST_DONE: begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            base      <= '0;
            count     <= '0;
            data      <= '0;
            remaining <= '0;
            out_addr  <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            base      <= base_n;
            count     <= count_n;
            data      <= data_n;
            remaining <= rem_n;
            out_addr  <= addr_n;
            done      <= done_n;
            aborted   <= aborted_n;
        end
    end

`ifdef ADDR_SEQ_IRQ_EN
    logic irq_en_n, irq_q;
    assign irq_en_n = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en;
    assign irq      = irq_q;

    // irq is computed from next-state values so it tracks done && irq_en with no lag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            irq_en <= irq_en_n;
            irq_q  <= done_n && irq_en_n;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            REG_BASE:  readdata = base;
            REG_COUNT: readdata[COUNT_W-1:0] = remaining;
            REG_DATA:  readdata = data;
            default: begin
                readdata[STAT_BUSY]    = busy;
                readdata[STAT_DONE]    = done;
                readdata[STAT_ABORTED] = aborted;
                readdata[STAT_IRQ_EN]  = irq_en;
            end
        endcase
    end

endmodule

// File: tb/tb_nios_system_addr_seq.sv
// Directed bench for nios_system_addr_seq: hand-computed expectations, immediate assertions.
module tb_nios_system_addr_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, out_addr, out_data;
    logic        out_wr, out_ready = 1'b0, irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] rv;
    int acc;

`ifdef ADDR_SEQ_IRQ_EN
    localparam logic [31:0] IRQ_EN_BIT = 32'h8;
    localparam logic [31:0] IRQ_EXP    = 32'h1;
`else
    localparam logic [31:0] IRQ_EN_BIT = 32'h0;
    localparam logic [31:0] IRQ_EXP    = 32'h0;
`endif

    nios_system_addr_seq #(.COUNT_W(16), .STRIDE(1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_addr(out_addr), .out_data(out_data), .out_wr(out_wr),
        .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write is sampled on the next rising edge.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_wr", {31'b0, out_wr}, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        bus_rd(2'd3, rv); chk("rst_status", rv, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic run, out_ready held high
        bus_wr(2'd0, 32'h100);
        bus_wr(2'd1, 32'd4);
        bus_wr(2'd2, 32'hA5A5A5A5);
        out_ready = 1'b1;
        bus_wr(2'd3, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("run_wr", {31'b0, out_wr}, 32'h1);
            chk("run_addr", out_addr, 32'h100 + i);
            chk("run_data", out_data, 32'hA5A5A5A5);
            @(negedge clk);
        end
        chk("run_wr_low", {31'b0, out_wr}, 32'h0);
        @(negedge clk);
        bus_rd(2'd3, rv); chk("run_status", rv, 32'h2);
        bus_rd(2'd1, rv); chk("run_remaining", rv, 32'h0);
        chk("run_addr_end", out_addr, 32'h104);
        @(negedge clk);

        // Same run with out_ready toggling
        out_ready = 1'b0;
        bus_wr(2'd3, 32'h1);
        acc = 0;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            out_ready = c[0];
            if (out_wr) begin
                chk("bp_addr", out_addr, 32'h100 + acc);
                if (out_ready) acc++;
            end
            @(negedge clk);
        end
        chk("bp_accepts", acc, 32'd4);
        chk("bp_wr_low", {31'b0, out_wr}, 32'h0);
        @(negedge clk);
        bus_rd(2'd3, rv); chk("bp_status", rv, 32'h2);
        @(negedge clk);

        // Zero count: straight to DONE, optional irq
        bus_wr(2'd1, 32'd0);
        bus_wr(2'd3, 32'h9);
        chk("zero_no_wr", {31'b0, out_wr}, 32'h0);
        @(negedge clk);
        bus_rd(2'd3, rv); chk("zero_status", rv, 32'h2 | IRQ_EN_BIT);
        chk("zero_irq", {31'b0, irq}, IRQ_EXP);
        chk("zero_no_wr2", {31'b0, out_wr}, 32'h0);
        @(negedge clk);
        bus_wr(2'd3, 32'hC);
        bus_rd(2'd3, rv); chk("clr_status", rv, IRQ_EN_BIT);
        chk("clr_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);

        // Done-clear in the same cycle done is set keeps done
        bus_wr(2'd3, 32'h1);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3, rv); chk("clr_race_status", rv, 32'h2);
        @(negedge clk);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3, rv); chk("clr_after_status", rv, 32'h0);
        @(negedge clk);

        // Address wrap
        bus_wr(2'd0, 32'hFFFFFFFE);
        bus_wr(2'd1, 32'd3);
        out_ready = 1'b1;
        bus_wr(2'd3, 32'h1);
        chk("wrap_a0", out_addr, 32'hFFFFFFFE); @(negedge clk);
        chk("wrap_a1", out_addr, 32'hFFFFFFFF); @(negedge clk);
        chk("wrap_a2", out_addr, 32'h00000000); @(negedge clk);
        chk("wrap_wr_low", {31'b0, out_wr}, 32'h0);
        chk("wrap_addr_end", out_addr, 32'h1);
        @(negedge clk); @(negedge clk);

        // Abort after 3 accepts
        bus_wr(2'd0, 32'h200);
        bus_wr(2'd1, 32'd10);
        bus_wr(2'd3, 32'h1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        out_ready = 1'b0;
        bus_wr(2'd3, 32'h2);
        chk("abort_wr_low", {31'b0, out_wr}, 32'h0);
        bus_rd(2'd3, rv); chk("abort_status", rv, 32'h4);
        bus_rd(2'd1, rv); chk("abort_remaining", rv, 32'd7);
        chk("abort_addr", out_addr, 32'h203);
        @(negedge clk);

        // Accept in the same cycle as abort still counts
        out_ready = 1'b1;
        bus_wr(2'd3, 32'h1);
        bus_wr(2'd3, 32'h2);
        chk("abacc_wr_low", {31'b0, out_wr}, 32'h0);
        bus_rd(2'd1, rv); chk("abacc_remaining", rv, 32'd9);
        chk("abacc_addr", out_addr, 32'h201);
        @(negedge clk);

        // Start with abort in one write: abort only, nothing starts
        bus_wr(2'd3, 32'h3);
        chk("stab_no_wr", {31'b0, out_wr}, 32'h0);
        bus_rd(2'd3, rv); chk("stab_status", rv, 32'h4);
        @(negedge clk);

        // Config writes ignored while busy, then reset mid-run
        bus_wr(2'd0, 32'h300);
        out_ready = 1'b0;
        bus_wr(2'd3, 32'h1);
        chk("busy_wr", {31'b0, out_wr}, 32'h1);
        bus_wr(2'd0, 32'h999);
        bus_wr(2'd2, 32'h12345678);
        bus_rd(2'd0, rv); chk("busy_base", rv, 32'h300);
        chk("busy_data", out_data, 32'hA5A5A5A5);
        chk("busy_hold_addr", out_addr, 32'h300);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_out_wr", {31'b0, out_wr}, 32'h0);
        chk("mrst_out_addr", out_addr, 32'h0);
        chk("mrst_out_data", out_data, 32'h0);
        chk("mrst_irq", {31'b0, irq}, 32'h0);
        bus_rd(2'd0, rv); chk("mrst_base", rv, 32'h0);
        bus_rd(2'd3, rv); chk("mrst_status", rv, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wr", {31'b0, out_wr}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
